// File: rtl/sub_pkg.sv
// sub_pkg: shared types and constants for the bit-serial subtractor
//   sub_state_t        : control states IDLE / SHIFT / DONE (2-bit encoding)
//   SUB_WIDTH_DEFAULT  : default operand width
package sub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;
    localparam int SUB_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done request bundle between requester and subtractor
//   master drives start, A, B, Bi; slave drives busy, done, D, Bo
interface serial_subtractor_if #(parameter int WIDTH = sub_pkg::SUB_WIDTH_DEFAULT);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo;
    modport master(output start, A, B, Bi, input busy, done, D, Bo);
    modport slave(input start, A, B, Bi, output busy, done, D, Bo);
endinterface

// File: rtl/fullsubtractor.sv
// fullsubtractor: one-bit combinational subtractor cell
//   a, b, bi : minuend bit, subtrahend bit, borrow-in
//   d, bo    : difference bit, borrow-out
module fullsubtractor (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B - Bi, LSB first, one bit per clock
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the start/done bundle (start, A, B, Bi -> busy, done, D, Bo)
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    sub_state_t       state, nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr, d_q;
    logic [CW-1:0]    cnt;
    logic             bor, bo_q, d_bit, bo_bit, last;
    fullsubtractor u_fs (.d(d_bit), .bo(bo_bit), .a(a_sr[0]), .b(b_sr[0]), .bi(bor));
    assign last = cnt == LAST;
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_comb
        nxt = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            d_q     <= '0;
            cnt     <= '0;
            bor     <= 1'b0;
            bo_q    <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_sr    <= bus.A;
            b_sr    <= bus.B;
            bor     <= bus.Bi;
            diff_sr <= '0;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
            bor     <= bo_bit;
            // wrap to 0 on the last bit so the counter never passes WIDTH-1
            cnt     <= last ? '0 : cnt + 1'b1;
            if (last) begin
                d_q  <= {d_bit, diff_sr[WIDTH-1:1]};
                bo_q <= bo_bit;
            end
        end
    end
    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.D    = d_q;
    assign bus.Bo   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 4 and 8
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus4();
    serial_subtractor_if #(.WIDTH(8)) bus8();
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    // Issue one request on the chosen DUT, wait (bounded) for done, return result and timing.
    task automatic do_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output int lat, output int busy_n, output logic [7:0] d, output logic bo);
        if (w8) begin
            bus8.A = a; bus8.B = b; bus8.Bi = bi; bus8.start = 1'b1;
        end else begin
            bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.Bi = bi; bus4.start = 1'b1;
        end
        @(posedge clk); #1;
        bus4.start = 1'b0; bus8.start = 1'b0;
        bus4.A = 4'($urandom); bus4.B = 4'($urandom); bus4.Bi = 1'($urandom);
        bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.Bi = 1'($urandom);
        lat = 0;
        busy_n = 0;
        while (!(w8 ? bus8.done : bus4.done) && lat < 40) begin
            if (w8 ? bus8.busy : bus4.busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (w8) begin
            d = bus8.D; bo = bus8.Bo;
        end else begin
            d = {4'b0, bus4.D}; bo = bus4.Bo;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Bi = 1'b0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if ({bus4.busy, bus4.done, bus4.Bo} !== 3'b000) begin n_fail++; $display("FAIL reset4_flags got %b exp 000", {bus4.busy, bus4.done, bus4.Bo}); end
        n_cmp++; if (bus4.D !== 4'b0000) begin n_fail++; $display("FAIL reset4_D got %b exp 0000", bus4.D); end
        n_cmp++; if ({bus8.busy, bus8.done, bus8.Bo, bus8.D} !== 11'b0) begin n_fail++; $display("FAIL reset8 got %b exp 0", {bus8.busy, bus8.done, bus8.Bo, bus8.D}); end
    endtask

    task automatic test_basic();
        int lat, bn; logic [7:0] d; logic bo;
        do_op(1'b0, 8'b1000, 8'b0001, 1'b0, lat, bn, d, bo);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d exp 4", lat); end
        n_cmp++; if (bn !== 4) begin n_fail++; $display("FAIL basic_busy_cycles got %0d exp 4", bn); end
        n_cmp++; if (d[3:0] !== 4'b0111 || bo !== 1'b0) begin n_fail++; $display("FAIL basic_result got D=%b Bo=%b exp D=0111 Bo=0", d[3:0], bo); end
        n_cmp++; if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got done=%b busy=%b exp 0 0", bus4.done, bus4.busy); end
    endtask

    task automatic test_borrow();
        int lat, bn; logic [7:0] d; logic bo;
        do_op(1'b0, 8'b0001, 8'b0010, 1'b0, lat, bn, d, bo);
        n_cmp++; if (d[3:0] !== 4'b1111 || bo !== 1'b1) begin n_fail++; $display("FAIL borrow_1_2 got D=%b Bo=%b exp D=1111 Bo=1", d[3:0], bo); end
        do_op(1'b0, 8'b1111, 8'b1111, 1'b1, lat, bn, d, bo);
        n_cmp++; if (d[3:0] !== 4'b1111 || bo !== 1'b1) begin n_fail++; $display("FAIL borrow_f_f_bi got D=%b Bo=%b exp D=1111 Bo=1", d[3:0], bo); end
    endtask

    task automatic test_ignored_start();
        int dn = 0, dj = -1, j2 = 0;
        logic b5 = 1'bx, b6 = 1'bx, bo = 1'bx;
        logic [3:0] d = 'x;
        bus4.A = 4'b1010; bus4.B = 4'b1001; bus4.Bi = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.A = 4'b0000; bus4.B = 4'b0001;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            if (bus4.done) begin dn++; dj = j; d = bus4.D; bo = bus4.Bo; end
            if (j == 5) b5 = bus4.busy;
            if (j == 6) b6 = bus4.busy;
        end
        bus4.start = 1'b0;
        n_cmp++; if (dn !== 1 || dj !== 4) begin n_fail++; $display("FAIL ignored_single_done got count=%0d at=%0d exp 1 at 4", dn, dj); end
        n_cmp++; if (d !== 4'b0001 || bo !== 1'b0) begin n_fail++; $display("FAIL ignored_result got D=%b Bo=%b exp D=0001 Bo=0", d, bo); end
        n_cmp++; if (b5 !== 1'b0 || b6 !== 1'b1) begin n_fail++; $display("FAIL held_start_accept got busy5=%b busy6=%b exp 0 1", b5, b6); end
        while (!bus4.done && j2 < 20) begin @(posedge clk); #1; j2++; end
        n_cmp++; if (j2 !== 4 || bus4.D !== 4'b1111 || bus4.Bo !== 1'b1) begin n_fail++; $display("FAIL second_accept got wait=%0d D=%b Bo=%b exp 4 1111 1", j2, bus4.D, bus4.Bo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn = 0; logic [7:0] d; logic bo;
        bus4.A = 4'b0101; bus4.B = 4'b0011; bus4.Bi = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({bus4.busy, bus4.done, bus4.Bo, bus4.D} !== 7'b0) begin n_fail++; $display("FAIL reset_mid_clear got %b exp 0", {bus4.busy, bus4.done, bus4.Bo, bus4.D}); end
        repeat (6) begin @(posedge clk); #1; if (bus4.done) dn++; end
        n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d exp 0", dn); end
        do_op(1'b0, 8'b0101, 8'b0011, 1'b0, lat, bn, d, bo);
        n_cmp++; if (lat !== 4 || d[3:0] !== 4'b0010 || bo !== 1'b0) begin n_fail++; $display("FAIL after_reset_op got lat=%0d D=%b Bo=%b exp 4 0010 0", lat, d[3:0], bo); end
    endtask

    task automatic test_reset_with_start();
        int dn = 0;
        rst = 1'b1; bus4.start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd2;
        @(posedge clk); #1;
        rst = 1'b0; bus4.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (bus4.done || bus4.busy) dn++; end
        n_cmp++; if (dn !== 0) begin n_fail++; $display("FAIL reset_beats_start got active=%0d exp 0", dn); end
    endtask

    task automatic test_width8();
        int lat, bn; logic [7:0] d; logic bo;
        do_op(1'b1, 8'h00, 8'h01, 1'b0, lat, bn, d, bo);
        n_cmp++; if (lat !== 8 || bn !== 8) begin n_fail++; $display("FAIL w8_timing got lat=%0d busy=%0d exp 8 8", lat, bn); end
        n_cmp++; if (d !== 8'hFF || bo !== 1'b1) begin n_fail++; $display("FAIL w8_result got D=%h Bo=%b exp FF 1", d, bo); end
    endtask

    task automatic test_random();
        int lat, bn, diff, w;
        logic [7:0] a, b, d, exp_d; logic bi, bo, exp_bo;
        for (int i = 0; i < 60; i++) begin
            w  = (i % 2 == 0) ? 4 : 8;
            a  = 8'($urandom_range(0, (1 << w) - 1));
            b  = 8'($urandom_range(0, (1 << w) - 1));
            bi = 1'($urandom);
            diff   = int'(a) - int'(b) - int'(bi);
            exp_d  = 8'((diff + 256) % (1 << w));
            exp_bo = diff < 0;
            do_op(w == 8, a, b, bi, lat, bn, d, bo);
            n_cmp++;
            if (lat !== w || d !== exp_d || bo !== exp_bo) begin
                n_fail++;
                $display("FAIL random w=%0d A=%h B=%h Bi=%b got lat=%0d D=%h Bo=%b exp lat=%0d D=%h Bo=%b",
                         w, a, b, bi, lat, d, bo, w, exp_d, exp_bo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignored_start();
        test_reset_mid();
        test_reset_with_start();
        test_width8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
